uart_rx_frame_ctrl: RTL

Parametrised UART receive controller that replaces the fixed 8-bit shift/parity/stop sequencer in the receiver path. It oversamples the serial line, validates the start bit at mid-bit, assembles LSB-first data of configurable width, and checks parity and one or two stop bits. It delivers each frame through a valid/ready handshake with per-frame error flags and a sticky overrun flag. It sits between the baud-tick generator and the receive buffer.

---
 rtl/uart_rx_frame_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: oversampled start/data/parity/stop sequencing.
// Optional break detection is compiled in with `define UART_RX_BREAK_DETECT_EN.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst,
  input  logic                  sample_tick,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy,
  output logic                  break_det
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [3:0] B_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] B_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_RX_BREAK_DETECT_EN
    , BRK_WAIT
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [3:0]            bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  fin;
  logic                  rxs;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                  pbit_q, pbit_d;
  logic                  brk_q, brk_d;
`endif

  assign rxs = sync_q[1];

  always_comb begin
    sync_d       = {sync_q[0], rxd};
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bcnt_d       = bcnt_q;
    sh_d         = sh_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    fin          = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    pbit_d       = pbit_q;
    brk_d        = 1'b0;
`endif

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    if (sample_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            tcnt_d  = '0;
          end
        end
        START: begin
          if (tcnt_q == T_HALF) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            state_d = rxs ? IDLE : DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tcnt_q == T_FULL) begin
            tcnt_d = '0;
            sh_d   = {rxs, sh_q[DATA_WIDTH-1:1]};
            if (bcnt_q == B_DATA) begin
              bcnt_d  = '0;
              state_d = (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (tcnt_q == T_FULL) begin
            tcnt_d  = '0;
            perr_d  = (PARITY_MODE == 2) ? ~^{sh_q, rxs} : ^{sh_q, rxs};
            state_d = STOP;
`ifdef UART_RX_BREAK_DETECT_EN
            pbit_d  = rxs;
`endif
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tcnt_q == T_FULL) begin
            tcnt_d = '0;
            if (!rxs) ferr_d = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
            // all-zero frame with a low first stop sample is a line break
            if (bcnt_q == 4'd0 && !rxs && sh_q == '0 &&
                (PARITY_MODE == 0 || !pbit_q)) begin
              brk_d   = 1'b1;
              state_d = BRK_WAIT;
            end else
`endif
            if (bcnt_q == B_STOP) begin
              fin     = 1'b1;
              state_d = IDLE;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
`ifdef UART_RX_BREAK_DETECT_EN
        BRK_WAIT: begin
          if (rxs) state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end

    if (fin) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = sh_q;
        parity_err_d = perr_q;
        frame_err_d  = ferr_q | ~rxs;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q      <= IDLE;
      sync_q       <= 2'b11;
      tcnt_q       <= '0;
      bcnt_q       <= '0;
      sh_q         <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      pbit_q       <= 1'b0;
      brk_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      tcnt_q       <= tcnt_d;
      bcnt_q       <= bcnt_d;
      sh_q         <= sh_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
      pbit_q       <= pbit_d;
      brk_q        <= brk_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
  assign break_det  = brk_q;
`else
  assign break_det  = 1'b0;
`endif

endmodule
